// File: rtl/iob_ram_responder_pkg.sv
// Shared defaults, legality limits and helpers for the IOb RAM responder.
package iob_ram_responder_pkg;

    // Parameter defaults
    localparam int ADDR_W_DEF     = 32;
    localparam int DATA_W_DEF     = 32;
    localparam int MEM_ADDR_W_DEF = 10;
    localparam int READ_LAT_DEF   = 2;
    localparam int FIFO_DEPTH_DEF = 4;

    // Legal read-latency range
    localparam int READ_LAT_MIN = 1;
    localparam int READ_LAT_MAX = 4;

    // Request kind decoded from the byte strobes
    typedef enum logic {
        REQ_READ  = 1'b0,
        REQ_WRITE = 1'b1
    } req_kind_t;

    // Replace the strobed bytes of a stored word with the new data
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/iob_ram_responder_fifo.sv
// First-word-fall-through response FIFO; head word is visible while not empty.
module iob_ram_responder_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign empty    = (level == '0);
    assign full     = (level == LVL_W'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // Storage array: data only, never reset
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers and fill level
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
            level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
        end
    end

endmodule

// File: rtl/iob_ram_responder.sv
// IOb subordinate serving a byte-writable RAM; reads return after READ_LAT
// cycles through a credit-protected FWFT response FIFO.
module iob_ram_responder
    import iob_ram_responder_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MEM_ADDR_W = MEM_ADDR_W_DEF,
    parameter int READ_LAT   = READ_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                iob_valid_i,
    input  logic [ADDR_W-1:0]   iob_addr_i,
    input  logic [DATA_W-1:0]   iob_wdata_i,
    input  logic [DATA_W/8-1:0] iob_wstrb_i,
    output logic                iob_ready_o,
    output logic                iob_rvalid_o,
    output logic [DATA_W-1:0]   iob_rdata_o,
    input  logic                iob_rready_i
);
    localparam int WORDS  = 2 ** MEM_ADDR_W;
    localparam int OUTS_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OUTS_W-1:0] OUTS_MAX = OUTS_W'(FIFO_DEPTH);

    // Reject illegal configurations at elaboration
    generate
        if (READ_LAT < READ_LAT_MIN || READ_LAT > READ_LAT_MAX) begin : g_bad_lat
            $error("iob_ram_responder: READ_LAT must be within 1..4");
        end
        if (FIFO_DEPTH < READ_LAT + 1) begin : g_bad_depth
            $error("iob_ram_responder: FIFO_DEPTH must be at least READ_LAT+1");
        end
        if (DATA_W != 32) begin : g_bad_data
            $error("iob_ram_responder: DATA_W must be 32");
        end
    endgenerate

    logic [DATA_W-1:0]     mem [WORDS];
    logic [MEM_ADDR_W-1:0] word_idx;
    req_kind_t             kind;
    logic                  acc;
    logic                  rd_acc;
    logic                  wr_acc;
    logic                  pop;
    logic [OUTS_W-1:0]     outs;
    logic [OUTS_W-1:0]     outs_next;
    logic [DATA_W-1:0]     data_p [1:READ_LAT];
    logic [READ_LAT:1]     vld_p;
    logic [DATA_W-1:0]     fifo_head;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [OUTS_W-1:0]     fifo_level;
    logic [DATA_W-1:0]     rdata_hold;
    logic                  unused_bits;

    assign word_idx  = iob_addr_i[MEM_ADDR_W+1:2];
    assign kind      = (iob_wstrb_i == '0) ? REQ_READ : REQ_WRITE;
    assign acc       = iob_valid_i & iob_ready_o;
    assign rd_acc    = acc & (kind == REQ_READ);
    assign wr_acc    = acc & (kind == REQ_WRITE);
    assign pop       = iob_rvalid_o & iob_rready_i;
    assign outs_next = outs + OUTS_W'(rd_acc) - OUTS_W'(pop);

    assign unused_bits = ^{iob_addr_i[ADDR_W-1:MEM_ADDR_W+2], iob_addr_i[1:0],
                           fifo_full, fifo_level};

    // RAM contents: byte-merged writes at the accept edge, never reset
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem[word_idx] <= merge_bytes(mem[word_idx], iob_wdata_i, iob_wstrb_i);
    end

    // Stage 1 data: RAM word sampled at the read accept edge
    always_ff @(posedge clk_i) begin
        if (rd_acc) data_p[1] <= mem[word_idx];
    end

    // Stage 1 valid
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) vld_p[1] <= 1'b0;
        else           vld_p[1] <= rd_acc;
    end

    generate
        for (genvar k = 2; k <= READ_LAT; k++) begin : g_stage
            // Stage k data: plain delay, never stalls
            always_ff @(posedge clk_i) begin
                data_p[k] <= data_p[k-1];
            end

            // Stage k valid
            always_ff @(posedge clk_i or negedge arst_n_i) begin
                if (!arst_n_i) vld_p[k] <= 1'b0;
                else           vld_p[k] <= vld_p[k-1];
            end
        end
    endgenerate

    // Credit counter; ready is registered so a full FIFO is never pushed
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            outs        <= '0;
            iob_ready_o <= 1'b0;
        end else begin
            outs        <= outs_next;
            iob_ready_o <= (outs_next < OUTS_MAX);
        end
    end

    iob_ram_responder_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .arst_n    (arst_n_i),
        .push      (vld_p[READ_LAT]),
        .push_data (data_p[READ_LAT]),
        .pop       (pop),
        .pop_data  (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    // Last delivered word, shown on rdata while the FIFO is empty
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)  rdata_hold <= '0;
        else if (pop)   rdata_hold <= fifo_head;
    end

    assign iob_rvalid_o = ~fifo_empty;
    assign iob_rdata_o  = fifo_empty ? rdata_hold : fifo_head;

endmodule

// File: tb/tb_iob_ram_responder.sv
// Randomized and directed bench for iob_ram_responder against a queue-based model.
module tb_iob_ram_responder;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int MEM_ADDR_W = 10;
    localparam int READ_LAT   = 2;
    localparam int FIFO_DEPTH = 4;

    logic        clk    = 1'b0;
    logic        arst_n = 1'b1;
    logic        valid  = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [3:0]  wstrb  = '0;
    logic        rready = 1'b0;
    logic        ready;
    logic        rvalid;
    logic [31:0] rdata;

    int n_checks = 0;
    int n_errs   = 0;
    int acc_cnt  = 0;
    bit rnd_rr   = 1'b0;

    always #5 clk = ~clk;

    iob_ram_responder #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .MEM_ADDR_W (MEM_ADDR_W),
        .READ_LAT   (READ_LAT),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i        (clk),
        .arst_n_i     (arst_n),
        .iob_valid_i  (valid),
        .iob_addr_i   (addr),
        .iob_wdata_i  (wdata),
        .iob_wstrb_i  (wstrb),
        .iob_ready_o  (ready),
        .iob_rvalid_o (rvalid),
        .iob_rdata_o  (rdata),
        .iob_rready_i (rready)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: word memory, response queue with due cycles, credit rule
    typedef struct {
        logic [31:0] d;
        int          due;
    } rsp_t;

    rsp_t        rq[$];
    logic [31:0] m_mem [0:1023];
    int          cyc      = 0;
    logic        m_ready  = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_last   = '0;

    initial begin
        int  idx;
        bit  m_acc;
        bit  m_pop;
        rsp_t r;
        forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) begin
                rq.delete();
                m_ready  = 1'b0;
                m_rvalid = 1'b0;
                m_last   = '0;
            end else begin
                idx   = int'(addr[MEM_ADDR_W+1:2]);
                m_acc = valid && m_ready;
                m_pop = m_rvalid && rready;
                if (m_pop) begin
                    m_last = rq[0].d;
                    void'(rq.pop_front());
                end
                if (m_acc && wstrb != 4'h0) begin
                    for (int b = 0; b < 4; b++)
                        if (wstrb[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
                end else if (m_acc) begin
                    r.d   = m_mem[idx];
                    r.due = cyc + READ_LAT + 1;
                    rq.push_back(r);
                end
                cyc++;
                m_ready  = (rq.size() < FIFO_DEPTH);
                m_rvalid = (rq.size() > 0) && (rq[0].due <= cyc);
            end
        end
    end

    // Per-cycle comparison of the DUT outputs with the model
    initial begin
        forever begin
            @(negedge clk);
            check_eq("ready", 32'(ready), 32'(m_ready));
            check_eq("rvalid", 32'(rvalid), 32'(m_rvalid));
            check_eq("rdata", rdata, m_rvalid ? rq[0].d : m_last);
        end
    end

    // Count accepted requests as seen on the DUT handshake
    initial begin
        forever begin
            @(posedge clk);
            if (arst_n && valid && ready) acc_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Issue one request at a negedge and hold it until accepted
    task automatic req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        addr  = a;
        wdata = d;
        wstrb = s;
        valid = 1'b1;
        while (!ready && n < 100) begin
            if (rnd_rr) rready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        check_eq("req_ready", 32'(ready), 32'd1);
        @(negedge clk);
        valid = 1'b0;
        wstrb = '0;
    endtask

    // Wait for the next response; check latency from accept and its data
    task automatic wait_rvalid(input string tag, input logic [31:0] exp);
        int k = 0;
        while (!rvalid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check_eq({tag, "_lat"}, 32'(k), 32'(READ_LAT));
        check_eq({tag, "_data"}, rdata, exp);
    endtask

    task automatic drain();
        int n = 0;
        rready = 1'b1;
        while ((rvalid || rq.size() > 0) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check_eq("drain_rvalid", 32'(rvalid), 32'd0);
    endtask

    initial begin
        int     base;
        longint t0;
        int     w;
        #1 arst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ready", 32'(ready), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        arst_n = 1'b1;
        @(negedge clk);
        check_eq("ready_after_rst", 32'(ready), 32'd1);

        // Write then read back
        rready = 1'b1;
        req(32'h10, 32'hDEADBEEF, 4'hF);
        check_eq("wr_no_rvalid", 32'(rvalid), 32'd0);
        req(32'h10, 32'h0, 4'h0);
        wait_rvalid("wr_rd", 32'hDEADBEEF);

        // Byte strobes
        req(32'h10, 32'h11223344, 4'hF);
        req(32'h10, 32'hAABBCCDD, 4'h5);
        req(32'h10, 32'h0, 4'h0);
        wait_rvalid("bytes", 32'h11BB33DD);

        // Preload words 0..15, leaving word 4 with the merged value
        for (int i = 0; i < 16; i++)
            if (i != 4) req(32'(i * 4), 32'hC0DE0000 + 32'(i), 4'hF);
        drain();

        // Back-pressure: six reads with rready held low
        rready = 1'b0;
        base   = acc_cnt;
        fork
            begin
                for (int i = 0; i < 6; i++) req(32'(i * 4), 32'h0, 4'h0);
            end
            begin
                repeat (10) @(negedge clk);
                check_eq("bp_accepted", 32'(acc_cnt - base), 32'd4);
                check_eq("bp_ready", 32'(ready), 32'd0);
                check_eq("bp_rvalid", 32'(rvalid), 32'd1);
                check_eq("bp_head", rdata, 32'hC0DE0000);
                rready = 1'b1;
            end
        join
        drain();
        check_eq("bp_total", 32'(acc_cnt - base), 32'd6);

        // Throughput: 16 back-to-back reads
        rready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 16; i++) req(32'(i * 4), 32'h0, 4'h0);
        check_eq("tput_cycles", 32'(($time - t0) / 10), 32'd16);
        drain();

        // Randomized traffic on words 32..47 with ignored address bits set
        for (int i = 32; i < 48; i++) req(32'(i * 4), $urandom(), 4'hF);
        rnd_rr = 1'b1;
        for (int n = 0; n < 150; n++) begin
            w = $urandom_range(32, 47);
            rready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0)
                req(($urandom() & ~32'h0000_0FFC) | 32'(w * 4), $urandom(),
                    4'($urandom_range(1, 15)));
            else
                req(($urandom() & ~32'h0000_0FFC) | 32'(w * 4), $urandom(), 4'h0);
            if ($urandom_range(0, 3) == 0) begin
                rready = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
        end
        rnd_rr = 1'b0;
        drain();

        // Reset while reads are in flight
        rready = 1'b0;
        for (int i = 0; i < 3; i++) req(32'(i * 4), 32'h0, 4'h0);
        @(posedge clk);
        #2 arst_n = 1'b0;
        #1;
        check_eq("mid_rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("mid_rst_ready", 32'(ready), 32'd0);
        check_eq("mid_rst_rdata", rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        arst_n = 1'b1;
        rready = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("no_stale_rvalid", 32'(rvalid), 32'd0);
        req(32'h10, 32'h0, 4'h0);
        wait_rvalid("post_rst", 32'h11BB33DD);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
